// File: rtl/comm_tx_packetizer.sv
// Serializes one latched result packet {size, values, indices} onto the UART tx line, 8N1, LSB first.
// Optional even-parity bit per byte when COMM_TX_PARITY_EN is defined (8E1 frames).
module comm_tx_packetizer #(
    parameter int CLKS_PER_BIT = 5,
    parameter int MAX_BYTES    = 8,
    parameter int FIELD_W      = 8 * MAX_BYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [8+2*FIELD_W-1:0]   tx_data,
    output logic                     tx,
    output logic                     busy,
    output logic                     tx_complete,
    output logic [7:0]               byte_idx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_e;

    state_e               state_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [2:0]           bit_q;
    logic [7:0]           byte_cnt_q;
    logic [7:0]           last_q;
    logic [7:0]           n_q;
    logic [7:0]           size_q;
    logic [FIELD_W-1:0]   vals_q;
    logic [FIELD_W-1:0]   idx_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;

    logic [7:0]           n_in;
    logic [7:0]           k_v;
    logic [7:0]           k_i;
    logic [7:0]           cur_byte;

    // Handshake: start is a level sampled only in IDLE; acceptance is visible as busy rising.
    // There is no backpressure and no queueing of a start seen while busy or in DONE.
    assign n_in = (tx_data[8+2*FIELD_W-1 -: 8] > 8'(MAX_BYTES)) ? 8'(MAX_BYTES)
                                                                 : tx_data[8+2*FIELD_W-1 -: 8];

    // Byte 0 is the raw size, then n value bytes, then n index bytes, each field MSB byte first.
    always_comb begin
        k_v      = byte_cnt_q - 8'd1;
        k_i      = byte_cnt_q - n_q - 8'd1;
        cur_byte = size_q;
        if (byte_cnt_q != 8'd0) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
                if (byte_cnt_q <= n_q) begin
                    if (k_v == 8'(i)) cur_byte = vals_q[FIELD_W-1-8*i -: 8];
                end else begin
                    if (k_i == 8'(i)) cur_byte = idx_q[FIELD_W-1-8*i -: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_cnt_q <= '0;
            last_q     <= '0;
            n_q        <= '0;
            size_q     <= '0;
            vals_q     <= '0;
            idx_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (start) begin
                        size_q     <= tx_data[8+2*FIELD_W-1 -: 8];
                        vals_q     <= tx_data[2*FIELD_W-1 -: FIELD_W];
                        idx_q      <= tx_data[FIELD_W-1:0];
                        n_q        <= n_in;
                        last_q     <= n_in + n_in;
                        byte_cnt_q <= '0;
                        baud_q     <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= cur_byte[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef COMM_TX_PARITY_EN
                            tx_q    <= ^cur_byte;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= cur_byte[bit_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_PARITY: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (byte_cnt_q == last_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            tx_q    <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap.
                            byte_cnt_q <= byte_cnt_q + 8'd1;
                            tx_q       <= 1'b0;
                            state_q    <= S_START;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_DONE: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign tx_complete = done_q;
    assign byte_idx    = byte_cnt_q;

endmodule

// File: tb/tb_comm_tx_packetizer.sv
// Bench for comm_tx_packetizer: UART receiver model plus byte-list reference built from the packet rules.
// Honours COMM_TX_PARITY_EN for frame length and parity checking.
module tb_comm_tx_packetizer;

    localparam int CPB = 5;
`ifdef COMM_TX_PARITY_EN
    localparam int B = 11;
`else
    localparam int B = 10;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [135:0] tx_data;
    logic         tx;
    logic         busy;
    logic         tx_complete;
    logic [7:0]   byte_idx;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pkt_t0   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] rx_i[$];
    logic       rx_ok[$];
    int         rx_t[$];

    comm_tx_packetizer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .tx_data     (tx_data),
        .tx          (tx),
        .busy        (busy),
        .tx_complete (tx_complete),
        .byte_idx    (byte_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void build_exp(input logic [7:0] sz, input logic [63:0] v, input logic [63:0] ix);
        int n;
        exp_q.delete();
        exp_q.push_back(sz);
        n = (sz > 8) ? 8 : int'(sz);
        for (int i = 0; i < n; i++) exp_q.push_back(8'(v >> (56 - 8 * i)));
        for (int i = 0; i < n; i++) exp_q.push_back(8'(ix >> (56 - 8 * i)));
    endfunction

    function automatic void clear_rx();
        rx_q.delete();
        rx_i.delete();
        rx_ok.delete();
        rx_t.delete();
    endfunction

    // Host-side receiver: finds the start bit, samples each bit mid-cell.
    initial begin
        logic [7:0] b;
        logic       ok;
        int         t;
        logic [7:0] bi;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                t  = cyc;
                bi = byte_idx;
                repeat (CPB / 2) @(negedge clk);
                ok = (tx === 1'b0);
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(negedge clk);
                    b[j] = tx;
                end
`ifdef COMM_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                ok = ok && (tx === ^b);
`endif
                repeat (CPB) @(negedge clk);
                ok = ok && (tx === 1'b1);
                rx_q.push_back(b);
                rx_i.push_back(bi);
                rx_ok.push_back(ok);
                rx_t.push_back(t);
            end
        end
    end

    task automatic launch(input logic [7:0] sz, input logic [63:0] v, input logic [63:0] ix, input bit hold);
        @(negedge clk);
        tx_data = {sz, v, ix};
        start   = 1'b1;
        build_exp(sz, v, ix);
        @(negedge clk);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_tx", 32'(tx), 32'd0);
        check("accept_idx", 32'(byte_idx), 32'd0);
        if (!hold) start = 1'b0;
        pkt_t0 = cyc;
    endtask

    task automatic finish_pkt();
        bit found = 0;
        int nb    = exp_q.size();
        int m;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            if (tx_complete === 1'b1) found = 1;
        end
        check("done_seen", 32'(found), 32'd1);
        if (found) begin
            check("duration", 32'(cyc - pkt_t0), 32'(nb * B * CPB));
            check("done_busy", 32'(busy), 32'd0);
            check("done_tx", 32'(tx), 32'd1);
        end
        @(negedge clk);
        check("pulse_width", 32'(tx_complete), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("byte_count", 32'(rx_q.size()), 32'(nb));
        m = (rx_q.size() < nb) ? rx_q.size() : nb;
        for (int i = 0; i < m; i++) begin
            check($sformatf("byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
            check($sformatf("idx%0d", i), 32'(rx_i[i]), 32'(i));
            check($sformatf("frame%0d", i), 32'(rx_ok[i]), 32'd1);
            if (i > 0) check($sformatf("gap%0d", i), 32'(rx_t[i] - rx_t[i-1]), 32'(B * CPB));
        end
        clear_rx();
    endtask

    initial begin
        bit seen;
        int bad;
        rst     = 1'b1;
        start   = 1'b0;
        tx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tx_complete), 32'd0);
        check("rst_idx", 32'(byte_idx), 32'd0);
        rst = 1'b0;

        // T1: idle line after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_tx", 32'(tx), 32'd1);
            check("idle_busy0", 32'(busy), 32'd0);
            check("idle_done", 32'(tx_complete), 32'd0);
        end

        // T2, T3, T4 directed packets
        launch(8'd4, 64'h74FB7BFE_00000000, 64'h0000_0003_0000_0000, 0);
        finish_pkt();
        launch(8'd8, 64'h74FB7BFE978F83D7, 64'h0000_0001_0002_0003, 0);
        finish_pkt();
        launch(8'd0, 64'h1122334455667788, 64'h99AABBCCDDEEFF00, 0);
        finish_pkt();
        launch(8'h0C, 64'h0102030405060708, 64'hF1F2F3F4F5F6F7F8, 0);
        finish_pkt();

        // Randomized packets, including oversized sizes
        for (int r = 0; r < 6; r++) begin
            launch(8'($urandom_range(0, 12)), {$urandom, $urandom}, {$urandom, $urandom}, 0);
            finish_pkt();
        end
        launch(8'($urandom_range(9, 255)), {$urandom, $urandom}, {$urandom, $urandom}, 0);
        finish_pkt();

        // T5: start re-pulsed and data changed mid-packet
        launch(8'd8, 64'h74FB7BFE978F83D7, 64'h0000_0001_0002_0003, 0);
        repeat (100) @(negedge clk);
        start   = 1'b1;
        tx_data = {8'd2, $urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        tx_data = {8'd5, $urandom, $urandom, $urandom, $urandom};
        finish_pkt();

        // T5: start held through DONE restarts after one IDLE cycle
        launch(8'd3, {$urandom, $urandom}, {$urandom, $urandom}, 1);
        finish_pkt();
        @(negedge clk);
        check("hold_restart_busy", 32'(busy), 32'd1);
        check("hold_restart_tx", 32'(tx), 32'd0);
        start  = 1'b0;
        pkt_t0 = cyc;
        finish_pkt();

        // T6: async reset mid-packet, then a fresh packet
        launch(8'd8, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (byte_idx === 8'd3) seen = 1;
        end
        check("reach_byte3", 32'(seen), 32'd1);
        repeat (17) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_tx", 32'(tx), 32'd1);
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(tx_complete), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_complete !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        check("post_rst_quiet", 32'(bad), 32'd0);
        clear_rx();
        launch(8'd8, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        finish_pkt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
